// File: rtl/dot_product_scheduler_if.sv
// Client-side bus of the dot-product scheduler: parallel A/B vectors in,
// one-hot ack/response pulses and the shared result out.
interface dot_product_scheduler_if #(
   parameter int NUM_REQ   = 4,
   parameter int VEC_WIDTH = 64,
   parameter int RES_WIDTH = 19
);
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*VEC_WIDTH-1:0] req_a;
   logic [NUM_REQ*VEC_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]           ack;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [RES_WIDTH-1:0]         rsp_data;
   logic                         rsp_err;

   modport master (
      output req, req_a, req_b,
      input  ack, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req, req_a, req_b,
      output ack, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/dot_product_scheduler.sv
// Round-robin front end that shares one serial-input dot-product engine among
// NUM_REQ clients: latch A/B, stream them LSB first, return the engine result.
module dot_product_scheduler #(
   parameter int NUM_REQ   = 4,
   parameter int VEC_WIDTH = 64,
   parameter int RES_WIDTH = 19,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 Reset,
   dot_product_scheduler_if.slave cli,
   output logic                 busy,
   output logic                 eng_serial,
   output logic                 eng_start,
   input  logic                 eng_done,
   input  logic [RES_WIDTH-1:0] eng_data
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BIT_W = $clog2(VEC_WIDTH);
   localparam int TO_W  = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_SEND_A, S_SEND_B, S_WAIT_DONE, S_RESPOND
   } state_e;

   state_e               state_q;
   logic [IDX_W-1:0]     rr_q, owner_q;
   logic [VEC_WIDTH-1:0] a_sh_q, b_sh_q;
   logic [BIT_W-1:0]     bit_cnt_q;
   logic [TO_W-1:0]      to_cnt_q;
   logic [NUM_REQ-1:0]   ack_q, rsp_valid_q;
   logic [RES_WIDTH-1:0] rsp_data_q;
   logic                 rsp_err_q, busy_q, eng_serial_q, eng_start_q;

   logic [IDX_W-1:0]     grant_idx_d, rr_d;
   logic                 grant_vld_d;
   int                   scan_idx;

   // First requester at or above the rr pointer, wrapping modulo NUM_REQ.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      grant_idx_d = '0;
      grant_vld_d = 1'b0;
      scan_idx    = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = int'(rr_q) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!grant_vld_d && cli.req[scan_idx]) begin
            grant_vld_d = 1'b1;
            grant_idx_d = IDX_W'(scan_idx);
         end
      end
      rr_d = (grant_idx_d == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_d + 1'b1;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         rr_q         <= '0;
         owner_q      <= '0;
         a_sh_q       <= '0;
         b_sh_q       <= '0;
         bit_cnt_q    <= '0;
         to_cnt_q     <= '0;
         ack_q        <= '0;
         rsp_valid_q  <= '0;
         rsp_data_q   <= '0;
         rsp_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         eng_serial_q <= 1'b0;
         eng_start_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         unique case (state_q)
            S_IDLE: begin
               if (grant_vld_d) begin
                  a_sh_q      <= cli.req_a[grant_idx_d*VEC_WIDTH +: VEC_WIDTH];
                  b_sh_q      <= cli.req_b[grant_idx_d*VEC_WIDTH +: VEC_WIDTH];
                  owner_q     <= grant_idx_d;
                  rr_q        <= rr_d;
                  ack_q       <= NUM_REQ'(1) << grant_idx_d;
                  eng_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_START;
               end
            end
            // Each output bit is loaded one cycle ahead so eng_serial stays registered.
            S_START: begin
               ack_q        <= '0;
               eng_start_q  <= 1'b0;
               eng_serial_q <= a_sh_q[0];
               a_sh_q       <= a_sh_q >> 1;
               bit_cnt_q    <= BIT_W'(VEC_WIDTH - 1);
               state_q      <= S_SEND_A;
            end
            S_SEND_A: begin
               if (bit_cnt_q == '0) begin
                  eng_serial_q <= b_sh_q[0];
                  b_sh_q       <= b_sh_q >> 1;
                  bit_cnt_q    <= BIT_W'(VEC_WIDTH - 1);
                  state_q      <= S_SEND_B;
               end else begin
                  eng_serial_q <= a_sh_q[0];
                  a_sh_q       <= a_sh_q >> 1;
                  bit_cnt_q    <= bit_cnt_q - 1'b1;
               end
            end
            S_SEND_B: begin
               if (bit_cnt_q == '0) begin
                  eng_serial_q <= 1'b0;
                  to_cnt_q     <= '0;
                  state_q      <= S_WAIT_DONE;
               end else begin
                  eng_serial_q <= b_sh_q[0];
                  b_sh_q       <= b_sh_q >> 1;
                  bit_cnt_q    <= bit_cnt_q - 1'b1;
               end
            end
            // Done wins over an expiring timeout in the same cycle.
            S_WAIT_DONE: begin
               if (eng_done) begin
                  rsp_data_q  <= eng_data;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= NUM_REQ'(1) << owner_q;
                  state_q     <= S_RESPOND;
               end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= NUM_REQ'(1) << owner_q;
                  state_q     <= S_RESPOND;
               end else begin
                  to_cnt_q <= to_cnt_q + 1'b1;
               end
            end
            S_RESPOND: begin
               rsp_valid_q <= '0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cli.ack       = ack_q;
   assign cli.rsp_valid = rsp_valid_q;
   assign cli.rsp_data  = rsp_data_q;
   assign cli.rsp_err   = rsp_err_q;
   assign busy          = busy_q;
   assign eng_serial    = eng_serial_q;
   assign eng_start     = eng_start_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler: behavioural engine model plus
// ack/response scoreboards filled as each job is requested.
module tb_dot_product_scheduler;
   localparam int NUM_REQ   = 4;
   localparam int VEC_WIDTH = 64;
   localparam int RES_WIDTH = 19;
   localparam int TIMEOUT   = 255;

   typedef struct packed {
      logic [NUM_REQ-1:0]   vld;
      logic [RES_WIDTH-1:0] data;
      logic                 err;
   } rsp_t;

   logic                 clk = 1'b0;
   logic                 Reset;
   logic                 busy, eng_serial, eng_start, eng_done;
   logic [RES_WIDTH-1:0] eng_data;
   logic                 eng_stuck;

   dot_product_scheduler_if #(.NUM_REQ(NUM_REQ), .VEC_WIDTH(VEC_WIDTH), .RES_WIDTH(RES_WIDTH)) cli ();

   dot_product_scheduler #(
      .NUM_REQ(NUM_REQ), .VEC_WIDTH(VEC_WIDTH), .RES_WIDTH(RES_WIDTH), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .Reset      (Reset),
      .cli        (cli),
      .busy       (busy),
      .eng_serial (eng_serial),
      .eng_start  (eng_start),
      .eng_done   (eng_done),
      .eng_data   (eng_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_errors = 0;
   rsp_t rsp_exp_q[$];
   int   ack_exp_q[$];

   task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RES_WIDTH-1:0] dot(logic [63:0] a, logic [63:0] b);
      int unsigned s = 0;
      for (int i = 0; i < 8; i++) s += 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
      return RES_WIDTH'(s);
   endfunction

   // Engine model: collects 128 serial bits after Start, Done in the 5th cycle after the last bit.
   logic [127:0] eng_bits;
   int           eng_nbits, eng_wait;
   logic         eng_collect;
   always @(posedge clk or posedge Reset) begin
      if (Reset) begin
         eng_done <= 1'b0; eng_data <= '0; eng_collect <= 1'b0;
         eng_nbits <= 0; eng_wait <= 0; eng_bits <= '0;
      end else begin
         eng_done <= 1'b0;
         if (eng_start) begin
            eng_collect <= 1'b1;
            eng_nbits   <= 0;
         end else if (eng_collect) begin
            eng_bits[eng_nbits] <= eng_serial;
            eng_nbits <= eng_nbits + 1;
            if (eng_nbits == 127) begin
               eng_collect <= 1'b0;
               eng_wait    <= 4;
            end
         end
         if (eng_wait == 1) begin
            eng_wait <= 0;
            if (!eng_stuck) begin
               eng_done <= 1'b1;
               eng_data <= dot(eng_bits[63:0], eng_bits[127:64]);
            end
         end else if (eng_wait > 1) begin
            eng_wait <= eng_wait - 1;
         end
      end
   end

   // Scoreboard: every ack / response pulse is matched against the next expected entry.
   always @(negedge clk) begin
      if (!Reset) begin
         if (cli.ack != '0) begin
            if (ack_exp_q.size() == 0) check("ack_unexpected", cli.ack, 0);
            else check("ack_order", cli.ack, 128'(1) << ack_exp_q.pop_front());
         end
         if (cli.rsp_valid != '0) begin
            if (rsp_exp_q.size() == 0) check("rsp_unexpected", cli.rsp_valid, 0);
            else check("rsp", {cli.rsp_valid, cli.rsp_data, cli.rsp_err}, rsp_exp_q.pop_front());
         end
      end
   end

   task automatic set_client(int i, logic [63:0] a, logic [63:0] b);
      cli.req_a[i*VEC_WIDTH +: VEC_WIDTH] = a;
      cli.req_b[i*VEC_WIDTH +: VEC_WIDTH] = b;
   endtask

   task automatic expect_job(int i, logic [63:0] a, logic [63:0] b, logic err);
      rsp_t r;
      r.vld  = NUM_REQ'(1) << i;
      r.data = err ? '0 : dot(a, b);
      r.err  = err;
      ack_exp_q.push_back(i);
      rsp_exp_q.push_back(r);
   endtask

   task automatic wait_ack_left(int left, int budget, string tag);
      int n = 0;
      while (ack_exp_q.size() > left && n < budget) begin @(negedge clk); n++; end
      check(tag, ack_exp_q.size() <= left, 1);
   endtask

   task automatic wait_rsp_left(int left, int budget, string tag);
      int n = 0;
      while (rsp_exp_q.size() > left && n < budget) begin @(negedge clk); n++; end
      check(tag, rsp_exp_q.size() <= left, 1);
   endtask

   task automatic wait_rsp_pulse(int budget);
      int n = 0;
      while (cli.rsp_valid == '0 && n < budget) begin @(negedge clk); n++; end
   endtask

   initial begin
      logic [63:0]  a, b;
      logic [63:0]  va[NUM_REQ], vb[NUM_REQ];
      logic [127:0] serial;
      int           t0, n;

      cli.req = '0; cli.req_a = '0; cli.req_b = '0;
      eng_stuck = 1'b0;
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {cli.ack, cli.rsp_valid, cli.rsp_data, cli.rsp_err, busy, eng_serial, eng_start}, 0);
      Reset = 1'b0;
      @(negedge clk);

      // Single client 0, with exact latency and serial order.
      a = {8{8'h01}}; b = {8{8'h02}};
      set_client(0, a, b);
      expect_job(0, a, b, 1'b0);
      cli.req = 4'b0001;
      t0 = cyc;
      n = 0;
      while (cli.ack == '0 && n < 10) begin @(negedge clk); n++; end
      check("t1_ack_cycle", 128'(cyc - t0), 1);
      check("t1_eng_start", eng_start, 1);
      check("t1_busy", busy, 1);
      cli.req = '0;
      for (int k = 0; k < 128; k++) begin @(negedge clk); serial[k] = eng_serial; end
      check("t1_serial", serial, {b, a});
      wait_rsp_pulse(20);
      check("t1_rsp_cycle", 128'(cyc - t0), 135);
      wait_rsp_left(0, 5, "t1_rsp_wait");
      repeat (3) @(negedge clk);
      check("t1_rsp_hold", cli.rsp_data, dot(a, b));
      check("t1_idle", busy, 0);

      // Maximum-valued lanes from client 2.
      a = {8{8'hFF}}; b = {8{8'hFF}};
      set_client(2, a, b);
      expect_job(2, a, b, 1'b0);
      cli.req = 4'b0100;
      wait_ack_left(0, 10, "t2_ack_wait");
      cli.req = '0;
      wait_rsp_left(0, 200, "t2_rsp_wait");

      // Pointer now at 3: grant 3, then 1001 gives 0 followed by 3.
      va[3] = {$urandom, $urandom}; vb[3] = {$urandom, $urandom};
      set_client(3, va[3], vb[3]);
      expect_job(3, va[3], vb[3], 1'b0);
      cli.req = 4'b1000;
      wait_ack_left(0, 10, "t4_ack_wait");
      cli.req = '0;
      wait_rsp_left(0, 200, "t4_rsp_wait");
      va[0] = {$urandom, $urandom}; vb[0] = {$urandom, $urandom};
      set_client(0, va[0], vb[0]);
      expect_job(0, va[0], vb[0], 1'b0);
      expect_job(3, va[3], vb[3], 1'b0);
      cli.req = 4'b1001;
      wait_ack_left(1, 10, "t4_ack0_wait");
      cli.req[0] = 1'b0;
      wait_ack_left(0, 200, "t4_ack3_wait");
      cli.req[3] = 1'b0;
      wait_rsp_left(0, 200, "t4_rsp_drain");

      // All clients held high after reset: 0,1,2,3,0.
      Reset = 1'b1;
      repeat (2) @(negedge clk);
      Reset = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
         set_client(i, va[i], vb[i]);
      end
      for (int j = 0; j < 5; j++) expect_job(j % NUM_REQ, va[j % NUM_REQ], vb[j % NUM_REQ], 1'b0);
      cli.req = 4'b1111;
      wait_ack_left(0, 5*140 + 20, "t3_ack_wait");
      cli.req = '0;
      wait_rsp_left(0, 200, "t3_rsp_wait");

      // Engine never signals Done: timeout response to client 1.
      eng_stuck = 1'b1;
      expect_job(1, va[1], vb[1], 1'b1);
      cli.req = 4'b0010;
      t0 = cyc;
      wait_ack_left(0, 10, "t5_ack_wait");
      cli.req = '0;
      wait_rsp_pulse(500);
      check("t5_rsp_cycle", 128'(cyc - t0), 130 + TIMEOUT);
      wait_rsp_left(0, 5, "t5_rsp_wait");
      eng_stuck = 1'b0;

      // Reset in the middle of SEND_B abandons the job silently.
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      set_client(2, a, b);
      expect_job(2, a, b, 1'b0);
      cli.req = 4'b0100;
      wait_ack_left(0, 10, "t6_ack_wait");
      cli.req = '0;
      repeat (80) @(negedge clk);
      rsp_exp_q.delete();
      Reset = 1'b1;
      #1;
      check("t6_reset_outputs", {cli.ack, cli.rsp_valid, cli.rsp_data, cli.rsp_err, busy, eng_serial, eng_start}, 0);
      repeat (2) @(negedge clk);
      Reset = 1'b0;
      repeat (200) @(negedge clk);
      expect_job(2, a, b, 1'b0);
      cli.req = 4'b0100;
      wait_ack_left(0, 10, "t6_fresh_ack_wait");
      cli.req = '0;
      wait_rsp_left(0, 200, "t6_fresh_rsp_wait");

      repeat (5) @(negedge clk);
      check("sb_drain", 128'(rsp_exp_q.size() + ack_exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
